std_rrwr_arbiter: RTL

Round-robin write arbiter for one shared enable-gated register. Up to `REQ_COUNT` requesters compete each cycle to load the register. The winner's data is captured on the next clock edge. The block owns the register's enable and data mux and holds the rotating priority pointer. It sits between producer stages and any single shared state register in the pipeline, such as a status/CSR shadow or a shared result latch.

---
 rtl/std_rrwr_pkg.sv | 16 +
 rtl/std_dffre.sv | 26 ++
 rtl/std_rr_pick.sv | 39 +++
 rtl/std_rrwr_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/std_rrwr_pkg.sv
// std_rrwr_pkg: shared helpers for the round-robin write arbiter family.
//   idx_width(n) : index width for n requesters, clog2(n) with a minimum of 1
//   ptr_next(k,n): (k+1) mod n without a divider, safe for non-power-of-two n
package std_rrwr_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned ptr_next(input int unsigned k, input int unsigned n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/std_dffre.sv
// std_dffre: enable-gated register with synchronous active-low reset.
//   clk    : clock, rising edge
//   resetn : synchronous reset, active low, loads RESET_VALUE (wins over en)
//   en     : load enable
//   d      : next value
//   q      : registered value
module std_dffre #(
  parameter int unsigned       WIDTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/std_rr_pick.sv
// std_rr_pick: combinational rotating-priority picker.
//   req : request vector [N]
//   ptr : index where the ascending scan starts (must be < N)
//   gnt : one-hot winner, zero if no request
//   idx : binary index of the winner, zero if no request
//   any : at least one request present
module std_rr_pick
  import std_rrwr_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < N; off++) begin
      // Wrap by a single subtraction: ptr < N and off < N keep the sum below 2N.
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/std_rrwr_arbiter.sv
// std_rrwr_arbiter: round-robin write arbiter owning one shared register.
// Optional feature macro: STD_RRWR_ARBITER_LOCK_EN (adds i_lock).
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   i_hold  : freeze (no grant, no capture, pointer unchanged)
//   i_req   : per-requester write request [REQ_COUNT]
//   i_data  : packed write data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_lock  : (macro only) winner keeps top priority while locked
//   o_gnt   : one-hot grant, combinational
//   o_q     : registered shared value
//   o_valid : o_q written at least once since reset
//   o_src   : index of the requester that last wrote o_q
module std_rrwr_arbiter
  import std_rrwr_pkg::*;
#(
  parameter int unsigned           REQ_COUNT   = 4,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_hold,
  input  logic [REQ_COUNT-1:0]            i_req,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0] i_data,
`ifdef STD_RRWR_ARBITER_LOCK_EN
  input  logic [REQ_COUNT-1:0]            i_lock,
`endif
  output logic [REQ_COUNT-1:0]            o_gnt,
  output logic [DATA_WIDTH-1:0]           o_q,
  output logic                            o_valid,
  output logic [idx_width(REQ_COUNT)-1:0] o_src
);

  localparam int unsigned IW = idx_width(REQ_COUNT);

  logic [REQ_COUNT-1:0]  pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         ptr_d;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  en;
  logic                  resetn;

  std_rr_pick #(
    .N  (REQ_COUNT),
    .IW (IW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign resetn   = ~reset;
  assign en       = pick_any & ~i_hold;
  assign o_gnt    = (reset || i_hold) ? '0 : pick_gnt;
  assign win_data = i_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ptr_d = IW'(ptr_next(int'(pick_idx), REQ_COUNT));
`ifdef STD_RRWR_ARBITER_LOCK_EN
    if (i_lock[pick_idx]) ptr_d = pick_idx;
`endif
  end

  std_dffre #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_q (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .d      (win_data),
    .q      (o_q)
  );

  std_dffre #(
    .WIDTH       (IW),
    .RESET_VALUE ('0)
  ) u_src (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .d      (pick_idx),
    .q      (o_src)
  );

  std_dffre #(
    .WIDTH       (IW),
    .RESET_VALUE ('0)
  ) u_ptr (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .d      (ptr_d),
    .q      (ptr)
  );

  std_dffre #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_valid (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .d      (1'b1),
    .q      (o_valid)
  );

endmodule
